// File: rtl/rfid_pkg.sv
// rfid_pkg: shared command/slot encodings and Q-algorithm constants
package rfid_pkg;
  typedef enum logic [1:0] {CMD_QUERY = 2'd0, CMD_QUERYREP = 2'd1, CMD_QUERYADJ = 2'd2} cmd_t;
  typedef enum logic [1:0] {RES_EMPTY = 2'd0, RES_SINGLE = 2'd1, RES_COLL = 2'd2, RES_COLL_ALT = 2'd3} res_t;
  localparam int QFP_W = 8;
  localparam int Q_MAX = 15;
  localparam logic [QFP_W-1:0] QFP_MAX = 8'd240;
endpackage

// File: rtl/q_algo.sv
// q_algo: 4.4 fixed-point Q register, EMPTY/COLLISION step and rounding to integer Q
module q_algo import rfid_pkg::*; #(
  parameter int Q_INIT = 4,
  parameter int C_STEP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       upd,
  input  logic [1:0] res,
  output logic [3:0] q_new
);
  localparam logic [QFP_W-1:0] QFP_INIT = QFP_W'(Q_INIT * 16);
  localparam logic [QFP_W-1:0] STEP = QFP_W'(C_STEP);
  logic [QFP_W-1:0] qfp, qfp_upd;
  logic [QFP_W:0] inc;
  logic [QFP_W-4:0] rnd;
  assign inc = {1'b0, qfp} + {1'b0, STEP};
  assign rnd = (QFP_W-3)'((32'(qfp) + 32'd8) >> 4);
  assign q_new = (rnd > (QFP_W-3)'(Q_MAX)) ? 4'(Q_MAX) : rnd[3:0];
  // RES_COLL and its alias both fall through to the increment branch
  always_comb qfp_upd = (res == RES_EMPTY) ? ((qfp > STEP) ? qfp - STEP : '0)
                      : (res == RES_SINGLE) ? qfp
                      : ((inc > {1'b0, QFP_MAX}) ? QFP_MAX : inc[QFP_W-1:0]);
  always_ff @(posedge clk or posedge rst)
    if (rst) qfp <= QFP_INIT;
    else if (load) qfp <= QFP_INIT;
    else if (upd) qfp <= qfp_upd;
endmodule

// File: rtl/inventory_sched.sv
// inventory_sched: inventory round scheduler issuing QUERY/QUERYREP/QUERYADJ from slot outcomes
module inventory_sched import rfid_pkg::*; #(
  parameter int Q_INIT = 4,
  parameter int C_STEP = 4,
  parameter int SLOT_TIMEOUT = 30000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        round_start,
  input  logic        abort,
  input  logic        slot_done,
  input  logic [1:0]  slot_res,
  output logic        cmd_vld,
  input  logic        cmd_rdy,
  output logic [1:0]  cmd_type,
  output logic [3:0]  cmd_q,
  output logic        busy,
  output logic        round_done,
  output logic [15:0] tag_cnt,
  output logic [15:0] coll_cnt
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_SLOT, DECIDE, DONE} state_t;
  localparam int WD_W = $clog2(SLOT_TIMEOUT + 1);
  state_t state, nxt;
  cmd_t cmd;
  logic [3:0] q_cur, q_new;
  logic [14:0] slot_cnt;
  logic [WD_W-1:0] wdog;
  logic [1:0] res;
  logic start, wd_hit, evt, adj;
  assign start = state == IDLE && round_start && !abort;
  assign wd_hit = wdog == WD_W'(SLOT_TIMEOUT - 1);
  assign evt = state == WAIT_SLOT && !abort && (slot_done || wd_hit);
  assign res = slot_done ? slot_res : RES_EMPTY;
  assign adj = q_new != q_cur;
  assign cmd_vld = state == ISSUE;
  assign cmd_type = cmd;
  assign cmd_q = q_cur;
  assign busy = state != IDLE;
  assign round_done = state == DONE;
  q_algo #(.Q_INIT(Q_INIT), .C_STEP(C_STEP)) u_q (
    .clk(clk), .rst(rst), .load(start), .upd(evt), .res(res), .q_new(q_new)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = start ? ISSUE : IDLE;
      ISSUE:     nxt = cmd_rdy ? WAIT_SLOT : ISSUE;
      WAIT_SLOT: nxt = evt ? DECIDE : WAIT_SLOT;
      DECIDE:    nxt = (adj || slot_cnt != '0) ? ISSUE : DONE;
      default:   nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  // a 15-bit 1<<15 wraps to zero, so the minus one still yields 2^15-1
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q_cur <= 4'(Q_INIT);
      slot_cnt <= '0;
      tag_cnt <= '0;
      coll_cnt <= '0;
      cmd <= CMD_QUERY;
      wdog <= '0;
    end else begin
      wdog <= (state == WAIT_SLOT && !wd_hit) ? wdog + 1'b1 : '0;
      if (start) begin
        q_cur <= 4'(Q_INIT);
        slot_cnt <= (15'(1) << Q_INIT) - 1'b1;
        tag_cnt <= '0;
        coll_cnt <= '0;
        cmd <= CMD_QUERY;
      end
      if (evt && res == RES_SINGLE && tag_cnt != '1) tag_cnt <= tag_cnt + 1'b1;
      if (evt && res[1] && coll_cnt != '1) coll_cnt <= coll_cnt + 1'b1;
      if (state == DECIDE && !abort) begin
        if (adj) begin
          cmd <= CMD_QUERYADJ;
          q_cur <= q_new;
          slot_cnt <= (15'(1) << q_new) - 1'b1;
        end else if (slot_cnt != '0) begin
          cmd <= CMD_QUERYREP;
          slot_cnt <= slot_cnt - 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_inventory_sched.sv
// tb_inventory_sched: three parameterisations driven one at a time, transaction-level Q model and command scoreboard
module tb_inventory_sched;
  localparam int T = 12;
  localparam int C = 4;
  typedef struct { int k; logic [1:0] t; logic [3:0] q; } exp_t;
  logic clk = 0, rst = 1;
  logic [2:0] rs = 0, ab = 0, sd = 0, cr = 0, cv, busy, rd;
  logic [1:0] sr [3] = '{default: 2'd0};
  logic [1:0] ct [3];
  logic [3:0] cq [3];
  logic [15:0] tc [3], cc [3];
  int qi [3] = '{2, 0, 15};
  int n_chk = 0, n_fail = 0;
  int m_qfp, m_q, m_left, m_tag, m_coll;
  exp_t exp_q [$];
  exp_t e;
  logic hold_v [3];
  logic [1:0] h_t [3];
  logic [3:0] h_q [3];

  always #5 clk = ~clk;

  inventory_sched #(.Q_INIT(2), .C_STEP(C), .SLOT_TIMEOUT(T)) u2 (
    .clk(clk), .rst(rst), .round_start(rs[0]), .abort(ab[0]), .slot_done(sd[0]), .slot_res(sr[0]),
    .cmd_vld(cv[0]), .cmd_rdy(cr[0]), .cmd_type(ct[0]), .cmd_q(cq[0]), .busy(busy[0]),
    .round_done(rd[0]), .tag_cnt(tc[0]), .coll_cnt(cc[0]));
  inventory_sched #(.Q_INIT(0), .C_STEP(C), .SLOT_TIMEOUT(T)) u0 (
    .clk(clk), .rst(rst), .round_start(rs[1]), .abort(ab[1]), .slot_done(sd[1]), .slot_res(sr[1]),
    .cmd_vld(cv[1]), .cmd_rdy(cr[1]), .cmd_type(ct[1]), .cmd_q(cq[1]), .busy(busy[1]),
    .round_done(rd[1]), .tag_cnt(tc[1]), .coll_cnt(cc[1]));
  inventory_sched #(.Q_INIT(15), .C_STEP(C), .SLOT_TIMEOUT(T)) u15 (
    .clk(clk), .rst(rst), .round_start(rs[2]), .abort(ab[2]), .slot_done(sd[2]), .slot_res(sr[2]),
    .cmd_vld(cv[2]), .cmd_rdy(cr[2]), .cmd_type(ct[2]), .cmd_q(cq[2]), .busy(busy[2]),
    .round_done(rd[2]), .tag_cnt(tc[2]), .coll_cnt(cc[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Q-algorithm applied to one slot outcome; pushes the command that must follow
  task automatic model_slot(input int k, input int res, output bit done);
    int qn;
    if (res == 0) m_qfp = (m_qfp > C) ? m_qfp - C : 0;
    else if (res == 1) begin if (m_tag < 65535) m_tag++; end
    else begin
      m_qfp = (m_qfp + C > 240) ? 240 : m_qfp + C;
      if (m_coll < 65535) m_coll++;
    end
    qn = (m_qfp + 8) / 16;
    if (qn > 15) qn = 15;
    done = 0;
    if (qn != m_q) begin
      m_q = qn;
      m_left = (1 << qn) - 1;
      exp_q.push_back('{k, 2'd2, 4'(m_q)});
    end else if (m_left > 0) begin
      m_left--;
      exp_q.push_back('{k, 2'd1, 4'(m_q)});
    end else done = 1;
  endtask

  task automatic start_round(input int k);
    m_qfp = qi[k] * 16;
    m_q = qi[k];
    m_left = (1 << m_q) - 1;
    m_tag = 0;
    m_coll = 0;
    exp_q.push_back('{k, 2'd0, 4'(m_q)});
    rs[k] = 1;
    tick();
    rs[k] = 0;
    chk("start_busy", busy[k], 1);
  endtask

  task automatic abort_now(input int k);
    ab[k] = 1;
    rs[k] = 1;
    tick();
    ab[k] = 0;
    rs[k] = 0;
    chk("abort_vld", cv[k], 0);
    chk("abort_busy", busy[k], 0);
    chk("abort_no_done", rd[k], 0);
    exp_q.delete();
    tick();
    chk("abort_idle_no_done", rd[k], 0);
  endtask

  task automatic issue(input int k, input int hold, output bit ok);
    int n = 0;
    while (!cv[k] && n < 40) begin tick(); n++; end
    ok = cv[k];
    if (!ok) begin chk("cmd_vld_wait", cv[k], 1); return; end
    repeat (hold) begin
      sd[k] = $urandom_range(0, 2) == 0;
      sr[k] = 2'($urandom_range(0, 3));
      tick();
      sd[k] = 0;
    end
    cr[k] = 1;
    tick();
    cr[k] = 0;
  endtask

  task automatic slot(input int k, input int res, input bit to, output bit done);
    int n = 0;
    repeat ($urandom_range(0, 3)) begin
      rs[k] = $urandom_range(0, 3) == 0;
      tick();
      rs[k] = 0;
    end
    model_slot(k, to ? 0 : res, done);
    if (!to) begin
      sr[k] = 2'(res);
      sd[k] = 1;
      tick();
      sd[k] = 0;
      chk("lat_low", cv[k], 0);
      tick();
      if (done) chk("round_done", rd[k], 1);
      else chk("lat_vld", cv[k], 1);
    end else begin
      while (!cv[k] && !rd[k] && n < T + 8) begin tick(); n++; end
      if (done) chk("to_round_done", rd[k], 1);
      else chk("to_vld", cv[k], 1);
    end
    if (done) begin
      chk("tag_cnt", tc[k], m_tag);
      chk("coll_cnt", cc[k], m_coll);
      tick();
      chk("done_busy", busy[k], 0);
      chk("done_pulse", rd[k], 0);
      chk("tag_hold", tc[k], m_tag);
    end
  endtask

  task automatic run_round(input int k, input int n, input logic [31:0] code,
                           input logic [15:0] to_mask, input int hold, input bit rnd);
    bit ok, done, t;
    int r;
    start_round(k);
    for (int i = 0; i < n; i++) begin
      issue(k, hold < 0 ? int'($urandom_range(0, 5)) : hold, ok);
      if (!ok || (rnd && $urandom_range(0, 19) == 0)) begin abort_now(k); return; end
      r = rnd ? int'($urandom_range(0, 3)) : int'(code[2*i +: 2]);
      t = rnd ? ($urandom_range(0, 7) == 0) : to_mask[i];
      slot(k, r, t, done);
      if (done) return;
    end
    abort_now(k);
  endtask

  task automatic check_reset_all();
    for (int k = 0; k < 3; k++) begin
      chk("rst_vld", cv[k], 0);
      chk("rst_type", ct[k], 0);
      chk("rst_q", cq[k], qi[k]);
      chk("rst_busy", busy[k], 0);
      chk("rst_done", rd[k], 0);
      chk("rst_tag", tc[k], 0);
      chk("rst_coll", cc[k], 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) hold_v[k] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (cv[k] && hold_v[k]) begin
          chk("stable_type", ct[k], h_t[k]);
          chk("stable_q", cq[k], h_q[k]);
        end
        hold_v[k] = cv[k] && !cr[k];
        h_t[k] = ct[k];
        h_q[k] = cq[k];
        if (cv[k] && cr[k]) begin
          if (exp_q.size() == 0) chk("unexpected_cmd", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("cmd_inst", k, e.k);
            chk("cmd_type", ct[k], e.t);
            chk("cmd_q", cq[k], e.q);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    rst = 0;
    tick();
    check_reset_all();
    run_round(0, 5, 32'h140, 16'h0, 5, 0);
    run_round(1, 1, 32'h2, 16'h0, -1, 0);
    run_round(1, 1, 32'h0, 16'h0, -1, 0);
    run_round(2, 2, 32'hE, 16'h0, -1, 0);
    run_round(0, 3, 32'h0, 16'h7, -1, 0);
    ab[0] = 1;
    rs[0] = 1;
    tick();
    ab[0] = 0;
    rs[0] = 0;
    chk("idle_abort_busy", busy[0], 0);
    tick();
    chk("idle_abort_vld", cv[0], 0);
    start_round(0);
    #2 rst = 1;
    #1 chk("rst_async_vld", cv[0], 0);
    tick();
    rst = 0;
    exp_q.delete();
    tick();
    check_reset_all();
    repeat (24) run_round($urandom_range(0, 2), 30, 32'h0, 16'h0, -1, 1);
    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
